apu_mixer_gen3: RTL and testbench
=================================

# apu_mixer_gen3

Parametrised successor mixer for the APU audio path. It sums the pulse, triangle, noise and DMC channel levels with the standard non-linear-approximation gains and applies a per-channel mute and master volume. The mixed sample drives a 1-bit audio pin through a selectable PWM or first-order sigma-delta modulator of configurable resolution. It sits between the APU channel generators and the board audio pin, and also exports the parallel sample for other consumers.

## Interface
- PWM_BITS, 8, output resolution in bits; legal range 6..12.
- MODE, 0, modulator select: 0 = PWM, 1 = sigma-delta.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- from_pulse1  in  4  pulse 1 level.
- from_pulse2  in  4  pulse 2 level.
- from_triangle  in  4  triangle level.
- from_noise  in  4  noise level.
- from_dmc  in  7  DMC level.
- channel_mute  in  5  per-channel mute. Bit 0 = pulse1, 1 = pulse2, 2 = triangle, 3 = noise, 4 = dmc. A set bit forces that channel to 0.
- master_volume  in  4  master gain, applied as (v+1)/16; 15 = unity.
- sample_out  out  PWM_BITS  mixed, volume-scaled sample.
- period_tick  out  1  one-cycle pulse on every modulator period boundary.
- audio_out  out  1  modulated 1-bit audio.

## Operation
- Stage 1: register all channel inputs; muted channels are registered as 0.
- Stage 2: combined_pulse (5 bits) = pulse1 + pulse2.
- Stage 3: apply gains, each truncated by >>6.
  - pulse: (combined_pulse*144)>>6, range 0..67.
  - triangle: (triangle*162)>>6, range 0..37.
  - noise: (noise*94)>>6, range 0..22.
  - DMC: passed through with gain 1.
- Stage 4: mixed = full-width 8-bit sum of the four scaled values, maximum 253. There is no intermediate truncation anywhere.
- Stage 5: vol = (mixed*(master_volume+1))>>4, 8 bits.
- sample_out = vol scaled to PWM_BITS:
  - PWM_BITS ≥ 8: vol << (PWM_BITS-8).
  - PWM_BITS < 8: vol >> (8-PWM_BITS).
- PWM mode (MODE=0):
  - counter is PWM_BITS wide and free-running.
  - duty is loaded from sample_out only in the cycle where counter = all-ones. Duty is therefore glitch-free and constant across a whole period.
  - audio_out <= (duty > counter).
  - period_tick is registered high when counter wraps to 0.
- Sigma-delta mode (MODE=1):
  - acc is PWM_BITS+1 bits.
  - acc <= {1'b0, acc[PWM_BITS-1:0]} + sample_out.
  - audio_out <= acc carry bit.
  - The period counter still runs; period_tick behaves identically to PWM mode.
- Boundary behaviour:
  - sample_out = 0 gives audio_out permanently 0.
  - The maximum sample (253 at 8 bits) gives 253 high cycles per 256-cycle period.
  - Output is never 100% duty.

## Timing
- Reset: every register clears to 0, including hold registers, pipeline, counter, duty, acc, sample_out, period_tick and audio_out.
- Reset asserted mid-operation clears everything on the next edge. Output restarts from counter=0.
- Latency: an input change is visible on sample_out 5 cycles later.
- In PWM mode, the new sample reaches audio_out at the next counter wrap, plus 1 cycle for the output register.
- mute and volume changes enter at stage 1 and stage 5 respectively, so their latency is 5 and 1 cycles.
- There are no handshakes; the input channels are sampled every cycle.

## Structure
- Shared package apu_mixer_pkg holds:
  - gain constants GAIN_PULSE=144, GAIN_TRI=162, GAIN_NOISE=94, GAIN_SHIFT=6;
  - mute bit indices;
  - MODE_PWM/MODE_SD constants.
- The existing multiplier block is reused for the three gain products and the volume product.
- One sub-module, apu_mixer_modulator (PWM_BITS, MODE), contains the counter, duty, accumulator, period_tick and audio_out.

## Test plan
- Reset: hold rst 3 cycles with all channels at maximum. Required: audio_out, sample_out and period_tick all 0 during reset. After release, sample_out stays 0 for 5 cycles.
- Full scale (PWM_BITS=8, vol=15, no mute, all 4-bit channels 15, DMC 127):
  - sample_out=253.
  - audio_out is high for exactly 253 of each 256 cycles.
  - period_tick fires every 256 cycles.
- Mute = 5'b10000 with the same inputs: sample_out=126. Mute = 5'b11111: audio_out constantly 0.
- Volume, DMC-only 64 with vol=7: sample_out=32.
- Resolution, PWM_BITS=10 with full-scale inputs: sample_out=1012, period 1024 cycles.
- Duty stability and sigma-delta:
  - PWM: change the input when counter=100. Required: the high-time of the current period is unchanged; the new duty applies from the next wrap.
  - MODE=1, PWM_BITS=8, sample 64: audio_out is high exactly 1 cycle in every 4.

Source files
------------

// File: rtl/apu_mixer_pkg.sv
// Shared constants and pipeline stage types for the APU mixer.
package apu_mixer_pkg;

  localparam int GAIN_PULSE = 144;
  localparam int GAIN_TRI   = 162;
  localparam int GAIN_NOISE = 94;
  localparam int GAIN_SHIFT = 6;

  localparam int MUTE_PULSE1  = 0;
  localparam int MUTE_PULSE2  = 1;
  localparam int MUTE_TRIANGLE = 2;
  localparam int MUTE_NOISE   = 3;
  localparam int MUTE_DMC     = 4;

  localparam int MODE_PWM = 0;
  localparam int MODE_SD  = 1;

  typedef struct packed {
    logic [3:0] pulse1;
    logic [3:0] pulse2;
    logic [3:0] triangle;
    logic [3:0] noise;
    logic [6:0] dmc;
  } chan_t;

  typedef struct packed {
    logic [4:0] pulse;
    logic [3:0] triangle;
    logic [3:0] noise;
    logic [6:0] dmc;
  } comb_t;

  typedef struct packed {
    logic [6:0] pulse;
    logic [5:0] triangle;
    logic [5:0] noise;
    logic [6:0] dmc;
  } scaled_t;

endpackage

// File: rtl/apu_mixer_gen3_modulator.sv
// Period counter plus PWM / first-order sigma-delta 1-bit modulator.
module apu_mixer_modulator
  import apu_mixer_pkg::*;
#(
  parameter int PWM_BITS = 8,
  parameter int MODE     = MODE_PWM
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] sample,
  output logic                period_tick,
  output logic                audio_out
);
  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  logic [PWM_BITS-1:0] counter;
  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS:0]   acc;
  logic                wrap;

  assign wrap = (counter == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      counter     <= '0;
      duty        <= '0;
      acc         <= '0;
      period_tick <= 1'b0;
      audio_out   <= 1'b0;
    end else begin
      counter     <= counter + 1'b1;
      period_tick <= wrap;
      // duty only moves at the period boundary so a period is never split
      if (wrap) duty <= sample;
      acc <= {1'b0, acc[PWM_BITS-1:0]} + {1'b0, sample};
      if (MODE == MODE_SD) audio_out <= acc[PWM_BITS];
      else                 audio_out <= (duty > counter);
    end
  end

endmodule

// File: rtl/apu_mixer_mult.sv
// Unsigned combinational multiplier shared by the gain and volume paths.
module apu_mixer_mult #(
  parameter int AW = 8,
  parameter int BW = 8
) (
  input  logic [AW-1:0]    a,
  input  logic [BW-1:0]    b,
  output logic [AW+BW-1:0] p
);
  assign p = (AW+BW)'(a) * (AW+BW)'(b);
endmodule

// File: rtl/apu_mixer_gen3.sv
// Five-stage APU channel mixer with mute, master volume and 1-bit modulator.
module apu_mixer_gen3
  import apu_mixer_pkg::*;
#(
  parameter int PWM_BITS = 8,
  parameter int MODE     = MODE_PWM
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          from_pulse1,
  input  logic [3:0]          from_pulse2,
  input  logic [3:0]          from_triangle,
  input  logic [3:0]          from_noise,
  input  logic [6:0]          from_dmc,
  input  logic [4:0]          channel_mute,
  input  logic [3:0]          master_volume,
  output logic [PWM_BITS-1:0] sample_out,
  output logic                period_tick,
  output logic                audio_out
);
  chan_t   s1;
  comb_t   s2;
  scaled_t s3;
  logic [7:0] mixed;

  logic [12:0] pulse_prod;
  logic [11:0] tri_prod;
  logic [11:0] noise_prod;
  logic [4:0]  vol_gain;
  logic [12:0] vol_prod;
  logic [7:0]  vol;
  logic [PWM_BITS-1:0] scaled;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      mixed <= '0;
      sample_out <= '0;
    end else begin
      s1.pulse1   <= channel_mute[MUTE_PULSE1]   ? '0 : from_pulse1;
      s1.pulse2   <= channel_mute[MUTE_PULSE2]   ? '0 : from_pulse2;
      s1.triangle <= channel_mute[MUTE_TRIANGLE] ? '0 : from_triangle;
      s1.noise    <= channel_mute[MUTE_NOISE]    ? '0 : from_noise;
      s1.dmc      <= channel_mute[MUTE_DMC]      ? '0 : from_dmc;

      s2.pulse    <= {1'b0, s1.pulse1} + {1'b0, s1.pulse2};
      s2.triangle <= s1.triangle;
      s2.noise    <= s1.noise;
      s2.dmc      <= s1.dmc;

      s3.pulse    <= 7'(pulse_prod >> GAIN_SHIFT);
      s3.triangle <= 6'(tri_prod   >> GAIN_SHIFT);
      s3.noise    <= 6'(noise_prod >> GAIN_SHIFT);
      s3.dmc      <= s2.dmc;

      // worst case 67+37+22+127 = 253, so 8 bits never overflow
      mixed <= 8'(s3.pulse) + 8'(s3.triangle) + 8'(s3.noise) + 8'(s3.dmc);

      sample_out <= scaled;
    end
  end

  apu_mixer_mult #(.AW(5), .BW(8)) u_mul_pulse (
    .a (s2.pulse), .b (8'(GAIN_PULSE)), .p (pulse_prod)
  );
  apu_mixer_mult #(.AW(4), .BW(8)) u_mul_tri (
    .a (s2.triangle), .b (8'(GAIN_TRI)), .p (tri_prod)
  );
  apu_mixer_mult #(.AW(4), .BW(8)) u_mul_noise (
    .a (s2.noise), .b (8'(GAIN_NOISE)), .p (noise_prod)
  );

  // volume is applied directly at the last stage, hence its 1-cycle latency
  assign vol_gain = {1'b0, master_volume} + 5'd1;
  apu_mixer_mult #(.AW(8), .BW(5)) u_mul_vol (
    .a (mixed), .b (vol_gain), .p (vol_prod)
  );
  assign vol = 8'(vol_prod >> 4);

  generate
    if (PWM_BITS >= 8) begin : g_up
      assign scaled = PWM_BITS'(vol) << (PWM_BITS - 8);
    end else begin : g_dn
      assign scaled = PWM_BITS'(vol >> (8 - PWM_BITS));
    end
  endgenerate

  apu_mixer_modulator #(.PWM_BITS(PWM_BITS), .MODE(MODE)) u_mod (
    .clk         (clk),
    .rst         (rst),
    .sample      (sample_out),
    .period_tick (period_tick),
    .audio_out   (audio_out)
  );

endmodule

// File: tb/tb_apu_mixer_gen3.sv
// Scoreboard bench: 8-bit PWM, 10-bit PWM and 8-bit sigma-delta mixers share one stimulus.
module tb_apu_mixer_gen3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] p1, p2, tri_l, noi, vol;
  logic [6:0] dmc;
  logic [4:0] mute;
  logic [7:0] s8, ssd;
  logic [9:0] s10;
  logic t8, t10, tsd, a8, a10, asd;
  logic [2:0] tick, aud;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {int due; int which; int exp;} samp_t;
  typedef struct {int start; int high; int len;} win_t;
  samp_t sq[$];
  win_t  wq[3][$];

  int ws[3], wh[3], wl[3];
  bit wok[3];
  bit sd_en = 1'b0;
  bit last_ok = 1'b0;
  int last_hi = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apu_mixer_gen3 #(.PWM_BITS(8), .MODE(0)) dut8 (
    .clk(clk), .rst(rst), .from_pulse1(p1), .from_pulse2(p2), .from_triangle(tri_l),
    .from_noise(noi), .from_dmc(dmc), .channel_mute(mute), .master_volume(vol),
    .sample_out(s8), .period_tick(t8), .audio_out(a8));
  apu_mixer_gen3 #(.PWM_BITS(10), .MODE(0)) dut10 (
    .clk(clk), .rst(rst), .from_pulse1(p1), .from_pulse2(p2), .from_triangle(tri_l),
    .from_noise(noi), .from_dmc(dmc), .channel_mute(mute), .master_volume(vol),
    .sample_out(s10), .period_tick(t10), .audio_out(a10));
  apu_mixer_gen3 #(.PWM_BITS(8), .MODE(1)) dutsd (
    .clk(clk), .rst(rst), .from_pulse1(p1), .from_pulse2(p2), .from_triangle(tri_l),
    .from_noise(noi), .from_dmc(dmc), .channel_mute(mute), .master_volume(vol),
    .sample_out(ssd), .period_tick(tsd), .audio_out(asd));

  assign tick = {tsd, t10, t8};
  assign aud  = {asd, a10, a8};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int samp_of(input int w);
    case (w)
      0: return int'(s8);
      1: return int'(s10);
      default: return int'(ssd);
    endcase
  endfunction

  task automatic drive(input int a, input int b, input int c, input int d,
                       input int e, input int m, input int v);
    p1 = 4'(a); p2 = 4'(b); tri_l = 4'(c); noi = 4'(d);
    dmc = 7'(e); mute = 5'(m); vol = 4'(v);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_s(input int due, input int e8, input int e10, input int esd);
    sq.push_back('{due: due, which: 0, exp: e8});
    sq.push_back('{due: due, which: 1, exp: e10});
    sq.push_back('{due: due, which: 2, exp: esd});
  endtask

  // monitor: sample_out scoreboard plus per-period high-time measurement
  always @(negedge clk) begin
    while (sq.size() > 0 && sq[0].due <= cyc) begin
      samp_t it;
      it = sq.pop_front();
      chk($sformatf("sample_out_dut%0d", it.which), samp_of(it.which), it.exp);
    end
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        wok[i] = 1'b0;
      end else begin
        if (tick[i]) begin
          if (wok[i] && wq[i].size() > 0 && ws[i] >= wq[i][0].start) begin
            win_t w;
            w = wq[i].pop_front();
            chk($sformatf("period_len_dut%0d", i), wl[i], w.len);
            chk($sformatf("high_time_dut%0d", i), wh[i], w.high);
          end
          ws[i] = cyc; wh[i] = 0; wl[i] = 0; wok[i] = 1'b1;
        end
        wl[i] = wl[i] + 1;
        if (aud[i]) wh[i] = wh[i] + 1;
      end
    end
    if (sd_en && asd) begin
      if (last_ok) chk("sd_spacing", cyc - last_hi, 4);
      last_hi = cyc;
      last_ok = 1'b1;
    end
  end

  initial begin
    int k, t;
    bit found;
    drive(15, 15, 15, 15, 127, 0, 15);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_sample8", s8, 0);
      chk("rst_audio8", a8, 0);
      chk("rst_tick8", t8, 0);
      chk("rst_sample10", s10, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    k = cyc;
    push_s(k + 5, 253, 1012, 253);
    wq[0].push_back('{start: k + 6, high: 253, len: 256});
    wq[0].push_back('{start: k + 6 + 256, high: 253, len: 256});
    wq[1].push_back('{start: k + 6, high: 1012, len: 1024});
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_sample8", s8, 0);
    end
    step(2060);

    drive(15, 15, 15, 15, 127, 5'b10000, 15);
    push_s(cyc + 5, 126, 504, 126);
    wq[0].push_back('{start: cyc + 10, high: 126, len: 256});
    step(600);

    drive(15, 15, 15, 15, 127, 5'b11111, 15);
    push_s(cyc + 5, 0, 0, 0);
    wq[0].push_back('{start: cyc + 10, high: 0, len: 256});
    wq[2].push_back('{start: cyc + 10, high: 0, len: 256});
    step(600);

    drive(0, 0, 0, 0, 64, 0, 7);
    push_s(cyc + 5, 32, 128, 32);
    step(10);
    vol = 4'd15;
    sq.push_back('{due: cyc, which: 0, exp: 32});
    push_s(cyc + 1, 64, 256, 64);
    wq[0].push_back('{start: cyc + 10, high: 64, len: 256});
    wq[2].push_back('{start: cyc + 10, high: 64, len: 256});
    step(10);
    last_ok = 1'b0;
    sd_en = 1'b1;
    step(600);
    sd_en = 1'b0;

    found = 1'b0;
    for (int n = 0; n < 300 && !found; n++) begin
      @(negedge clk);
      if (t8) found = 1'b1;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL period_tick_wait: no tick within 300 cycles, expected one every 256");
    end else begin
      t = cyc;
      wq[0].push_back('{start: t, high: 64, len: 256});
      wq[0].push_back('{start: t + 256, high: 253, len: 256});
      repeat (100) @(posedge clk);
      #1;
      drive(15, 15, 15, 15, 127, 0, 15);
      sq.push_back('{due: cyc + 5, which: 0, exp: 253});
      step(600);
    end

    for (int i = 0; i < 3; i++) begin
      while (wq[i].size() > 0) begin
        win_t w;
        w = wq[i].pop_front();
        checks++; errors++;
        $display("FAIL period_unchecked_dut%0d: window from cycle %0d never measured, expected high %0d", i, w.start, w.high);
      end
    end
    while (sq.size() > 0) begin
      samp_t it;
      it = sq.pop_front();
      checks++; errors++;
      $display("FAIL sample_unchecked_dut%0d: due %0d never compared, expected %0d", it.which, it.due, it.exp);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
